display_scanner: RTL and testbench



---
 rtl/display_scanner.sv | 145 ++++++++++++++
 tb/tb_display_scanner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// display_scanner
// Time-multiplexes a frame of NUM_DIGITS 4-bit display codes onto a common
// multi-digit 7-segment display. One digit is scanned per refresh slot; the
// slot starts with a short all-anodes-off blanking interval to avoid ghosting.
// Frames are double-buffered: a load lands in the shadow buffer and is copied
// to the active buffer only on the frame-wrap cycle, so a frame never tears.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   load        one-cycle strobe capturing digits_in/enable_in into the shadow
//   digits_in   frame codes, nibble i = digit i, digit 0 rightmost
//   enable_in   per-digit enable, 0 blanks that position
//   bcd         code of the scanned digit (valid during blanking too)
//   anode       active-low digit select, at most one bit low
//   digit_idx   index of the scanned digit
//   pending     shadow holds a frame not yet committed
//   frame_done  one-cycle pulse after every frame wrap
//
// Load protocol: there is no backpressure. Every cycle with load == 1 is an
// accepted transfer; a later load before the commit simply replaces the
// shadow contents, so only the most recent frame is ever committed.
module display_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         enable_in,
  output logic [3:0]                    bcd,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          pending,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  // Scan position
  logic [CNT_W-1:0]        r_slot_cnt;
  logic [IDX_W-1:0]        r_idx;

  // Double-buffered frame
  logic [4*NUM_DIGITS-1:0] r_shadow_codes;
  logic [4*NUM_DIGITS-1:0] r_active_codes;
  logic [NUM_DIGITS-1:0]   r_shadow_en;
  logic [NUM_DIGITS-1:0]   r_active_en;
  logic                    r_pending;

  // Registered outputs
  logic [3:0]              r_bcd;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [IDX_W-1:0]        r_digit_idx;
  logic                    r_frame_done;

  // Decode of the current state
  logic                    w_slot_end;
  logic                    w_last_digit;
  logic                    w_wrap;
  logic                    w_commit;
  logic                    w_blanking;
  logic [3:0]              w_cur_code;
  logic [NUM_DIGITS-1:0]   w_anode_next;

  always_comb begin
    w_slot_end   = (r_slot_cnt == CNT_W'(REFRESH_DIV - 1));
    w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));
    w_wrap       = w_slot_end && w_last_digit;
    // Commit uses the shadow as it was before any same-cycle load, so a
    // load on the wrap cycle is kept for the following frame.
    w_commit     = w_wrap && r_pending;
    w_blanking   = (r_slot_cnt < CNT_W'(BLANK_CYCLES));
    w_cur_code   = r_active_codes[{r_idx, 2'b00} +: 4];
  end

  always_comb begin
    w_anode_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) == r_idx) && !w_blanking && r_active_en[i]) begin
        w_anode_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_cnt     <= '0;
      r_idx          <= '0;
      r_shadow_codes <= '0;
      r_active_codes <= '0;
      r_shadow_en    <= '0;
      r_active_en    <= '0;
      r_pending      <= 1'b0;
      r_bcd          <= '0;
      r_anode        <= '1;
      r_digit_idx    <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      // Slot / digit counters
      if (w_slot_end) begin
        r_slot_cnt <= '0;
        if (w_last_digit) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else begin
        r_slot_cnt <= r_slot_cnt + CNT_W'(1);
      end

      // Frame commit at the wrap
      if (w_commit) begin
        r_active_codes <= r_shadow_codes;
        r_active_en    <= r_shadow_en;
      end

      // Shadow capture; a load always leaves a frame pending, even on the
      // wrap cycle, because the freshly loaded data is not yet active.
      if (load) begin
        r_shadow_codes <= digits_in;
        r_shadow_en    <= enable_in;
        r_pending      <= 1'b1;
      end else if (w_commit) begin
        r_pending      <= 1'b0;
      end

      // Outputs reflect the state before this edge (one cycle latency)
      r_bcd        <= w_cur_code;
      r_digit_idx  <= r_idx;
      r_anode      <= w_anode_next;
      r_frame_done <= w_wrap;
    end
  end

  assign bcd        = r_bcd;
  assign anode      = r_anode;
  assign digit_idx  = r_digit_idx;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scanner.sv
// Testbench for display_scanner with NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYCLES=1 (16-cycle frame). A reference model of the scan advances
// alongside each driven cycle; its expected outputs are pushed into exp_q and
// popped/compared after the corresponding clock edge. Directed window
// statistics check the displayed codes, anode duty and frame_done timing.
module tb_display_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BL = 1;

  // Clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  enable_in = '0;
  logic [3:0]  bcd;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        pending;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .digits_in (digits_in),
    .enable_in (enable_in),
    .bcd       (bcd),
    .anode     (anode),
    .digit_idx (digit_idx),
    .pending   (pending),
    .frame_done(frame_done)
  );

  // Scoreboard: {bcd, anode, digit_idx, pending, frame_done}
  logic [11:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_slot = 0;
  int          m_idx  = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_active = '0;
  logic [3:0]  m_sh_en  = '0;
  logic [3:0]  m_act_en = '0;
  logic        m_pending = 1'b0;

  // Window statistics
  logic        watch_on = 1'b0;
  logic [15:0] watch_code = '0;
  int          viol = 0;
  int          low_cnt = 0;
  int          low_per[4];
  int          fd_cnt = 0;
  int          fd_first = -1;
  int          wcyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver: one clock cycle with the given inputs
  task automatic step(input logic rst, input logic ld, input logic [15:0] d, input logic [3:0] e);
    logic [3:0]  xb;
    logic [3:0]  xa;
    logic [1:0]  xi;
    logic        xf;
    logic        wrap;
    logic        commit;
    logic [11:0] exp_v;
    reset     = rst;
    load      = ld;
    digits_in = d;
    enable_in = e;
    xb = '0; xa = 4'hF; xi = '0; xf = 1'b0;
    if (rst) begin
      m_slot = 0; m_idx = 0;
      m_shadow = '0; m_active = '0; m_sh_en = '0; m_act_en = '0;
      m_pending = 1'b0;
    end else begin
      wrap   = (m_slot == RD - 1) && (m_idx == ND - 1);
      commit = wrap && m_pending;
      xb = m_active[4*m_idx +: 4];
      xi = m_idx[1:0];
      for (int i = 0; i < ND; i++) begin
        if (i == m_idx && m_slot >= BL && m_act_en[i]) xa[i] = 1'b0;
      end
      xf = wrap;
      if (commit) begin
        m_active = m_shadow;
        m_act_en = m_sh_en;
      end
      if (ld) begin
        m_shadow  = d;
        m_sh_en   = e;
        m_pending = 1'b1;
      end else if (commit) begin
        m_pending = 1'b0;
      end
      if (m_slot == RD - 1) begin
        m_slot = 0;
        m_idx  = (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else begin
        m_slot = m_slot + 1;
      end
    end
    exp_q.push_back({xb, xa, xi, m_pending, xf});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check("bcd",        32'(bcd),        32'(exp_v[11:8]));
    check("anode",      32'(anode),      32'(exp_v[7:4]));
    check("digit_idx",  32'(digit_idx),  32'(exp_v[3:2]));
    check("pending",    32'(pending),    32'(exp_v[1]));
    check("frame_done", 32'(frame_done), 32'(exp_v[0]));
    if (watch_on) begin
      wcyc++;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = wcyc;
      end
      if (anode !== 4'hF) begin
        low_cnt++;
        if (bcd !== watch_code[4*digit_idx +: 4]) viol++;
        for (int i = 0; i < ND; i++) begin
          if (anode[i] === 1'b0) low_per[i]++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  // Runs until the model is at the wrap cycle, then drives that cycle
  task automatic run_to_wrap(input logic ld, input logic [15:0] d, input logic [3:0] e);
    int n;
    n = 0;
    while (!(m_slot == RD - 1 && m_idx == ND - 1) && n < 64) begin
      step(1'b0, 1'b0, 16'h0, 4'h0);
      n++;
    end
    step(1'b0, ld, d, e);
  endtask

  task automatic watch_run(input logic [15:0] code, input int n);
    watch_code = code;
    viol = 0; low_cnt = 0; fd_cnt = 0; fd_first = -1; wcyc = 0;
    for (int i = 0; i < ND; i++) low_per[i] = 0;
    watch_on = 1'b1;
    idle(n);
    watch_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then idle 40 cycles
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    check("rst_anode", 32'(anode), 32'(4'hF));
    check("rst_bcd", 32'(bcd), 32'd0);
    watch_run(16'h0, 40);
    check("idle_anode_low", low_cnt, 0);
    check("idle_fd_first", fd_first, 16);
    check("idle_fd_count", fd_cnt, 2);

    // Mid-frame load of 3F1D, all enabled
    step(1'b0, 1'b1, 16'h3F1D, 4'hF);
    check("ld_pending", 32'(pending), 32'd1);
    run_to_wrap(1'b0, 16'h0, 4'h0);
    check("commit_pending_clr", 32'(pending), 32'd0);
    watch_run(16'h3F1D, 16);
    check("f3F1D_codes", viol, 0);
    check("f3F1D_low_cnt", low_cnt, 12);
    for (int i = 0; i < ND; i++) check("f3F1D_low_per", low_per[i], 3);

    // Two loads in one frame: only the later one is shown
    idle(2);
    step(1'b0, 1'b1, 16'h1111, 4'hF);
    idle(3);
    step(1'b0, 1'b1, 16'h2222, 4'hF);
    run_to_wrap(1'b0, 16'h0, 4'h0);
    watch_run(16'h2222, 16);
    check("f2222_codes", viol, 0);
    check("f2222_low_cnt", low_cnt, 12);

    // Load 5555 exactly on the wrap while 1111 is pending
    idle(2);
    step(1'b0, 1'b1, 16'h1111, 4'hF);
    run_to_wrap(1'b1, 16'h5555, 4'hF);
    check("wrapld_pending", 32'(pending), 32'd1);
    watch_run(16'h1111, 16);
    check("f1111_codes", viol, 0);
    check("f1111_low_cnt", low_cnt, 12);
    check("f5555_commit_pending", 32'(pending), 32'd0);
    watch_run(16'h5555, 16);
    check("f5555_codes", viol, 0);
    check("f5555_low_cnt", low_cnt, 12);

    // Partial enables
    step(1'b0, 1'b1, 16'h8888, 4'b0101);
    run_to_wrap(1'b0, 16'h0, 4'h0);
    watch_run(16'h8888, 16);
    check("en0101_codes", viol, 0);
    check("en0101_an0", low_per[0], 3);
    check("en0101_an1", low_per[1], 0);
    check("en0101_an2", low_per[2], 3);
    check("en0101_an3", low_per[3], 0);

    // Reset mid-frame with a pending frame and a simultaneous load
    idle(3);
    step(1'b0, 1'b1, 16'h4444, 4'hF);
    idle(2);
    step(1'b1, 1'b1, 16'h7777, 4'hF);
    check("mrst_anode", 32'(anode), 32'(4'hF));
    check("mrst_pending", 32'(pending), 32'd0);
    check("mrst_bcd", 32'(bcd), 32'd0);
    check("mrst_idx", 32'(digit_idx), 32'd0);
    check("mrst_fd", 32'(frame_done), 32'd0);
    watch_run(16'h0, 32);
    check("mrst_never_shown", low_cnt, 0);
    check("mrst_fd_first", fd_first, 16);
    check("mrst_fd_count", fd_cnt, 2);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
